wb_bus_dispatch: RTL and testbench
==================================

Name: wb_bus_dispatch

Overview:
- Parametrised Wishbone (classic) interconnect that sits between the SPI-to-Wishbone command builder (single master) and NUM_CHAN peripheral slaves, e.g. the clock counter and future stepper/scheduler blocks.
- Decodes the upper address bits to pick one slave channel, forwards the cycle to it, and registers the slave's response back to the master.
- Adds what a fixed single-slave router lacks: unmapped-address completion, a per-transaction ack timeout, mid-cycle abort handling and sticky error flags.

Parameters:
- NUM_CHAN, 4, number of slave channels; must satisfy NUM_CHAN <= 2**(ADDR_W-SUB_AW).
- ADDR_W, 7, master address width.
- SUB_AW, 4, slave-local address width; channel select = wb_adr_i[ADDR_W-1:SUB_AW].
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles a selected slave may take to ack; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  master strobe, cycle, write-enable
- wb_adr_i  in  ADDR_W  master address
- wb_dat_i  in  DATA_W  master write data
- wb_dat_o  out  DATA_W  read data to master
- wb_ack_o  out  1  ack to master
- s_wb_stb_o, s_wb_cyc_o  out  NUM_CHAN  per-channel strobe and cycle (one-hot)
- s_wb_we_o  out  1  shared write-enable
- s_wb_adr_o  out  SUB_AW  shared slave-local address
- s_wb_dat_o  out  DATA_W  shared write data
- s_wb_dat_i  in  NUM_CHAN*DATA_W  slave read data; channel n is bits [n*DATA_W +: DATA_W]
- s_wb_ack_i  in  NUM_CHAN  per-channel ack
- err_clr  in  1  clears the sticky error flags
- err_unmapped  out  1  sticky flag: an access targeted an unmapped channel
- err_timeout  out  1  sticky flag: a slave ack timed out

Behaviour:
- Clock and reset: one clock, clk. Reset (rst) is synchronous and active-high.
- Reset state:
  - FSM in IDLE.
  - All outputs are 0: wb_ack_o, wb_dat_o, s_wb_stb_o, s_wb_cyc_o, s_wb_we_o, s_wb_adr_o, s_wb_dat_o, err_unmapped and err_timeout.
  - Timeout counter is 0.
- The FSM has three states: IDLE, BUSY and ACK.
- IDLE:
  - On a clk edge where wb_cyc_i and wb_stb_i are both 1, latch sel = wb_adr_i[ADDR_W-1:SUB_AW], plus the low address bits, we and write data, into the slave-side registers.
  - If sel < NUM_CHAN: assert s_wb_stb_o[sel] and s_wb_cyc_o[sel] (registered, so visible the next cycle), clear the counter, go to BUSY.
  - If sel >= NUM_CHAN: no slave strobe; wb_dat_o=0, wb_ack_o=1 next cycle, set err_unmapped, go to ACK.
- BUSY:
  - The slave strobe is held. Each cycle, sample s_wb_ack_i[sel] only; acks from non-selected channels are ignored.
  - Selected ack = 1:
    - Drop the slave stb/cyc.
    - Register wb_dat_o = channel sel data on reads; writes return 0.
    - wb_ack_o=1 next cycle, go to ACK.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT:
    - Drop the slave stb/cyc.
    - wb_dat_o=0, wb_ack_o=1 next cycle.
    - Set err_timeout, go to ACK.
  - Slave ack and timeout in the same cycle: ack wins, no error.
  - wb_cyc_i=0 in BUSY (abort): drop the slave stb/cyc next cycle, no master ack, no error, go to IDLE.
- ACK:
  - wb_ack_o is 1 for exactly one cycle, then return to IDLE and clear wb_ack_o.
  - wb_dat_o holds its value until the next response.
- Latency:
  - Master request sampled at edge E produces slave strobe from E+1.
  - A combinational slave ack in the cycle after E+1 produces wb_ack_o in the cycle after E+2.
  - Minimum 2-cycle round trip; unmapped accesses take 1 cycle.
- Back-to-back: a request is accepted only in IDLE. The master's stb is ignored in BUSY and ACK; the master keeps stb asserted until it sees ack.
- Sticky flags: set-priority over err_clr when both happen on the same edge. Otherwise err_clr=1 clears both flags at the next edge.
- Reset mid-transaction: everything returns to the reset state at the next edge, including slave strobes and the flags.

Test Plan:
- Write 0x12345678 to address 0x05 (channel 0, local 5), slave 0 acks in its first strobe cycle -> s_wb_stb_o=4'b0001, s_wb_adr_o=5, s_wb_we_o=1, s_wb_dat_o=0x12345678; wb_ack_o one cycle, 3 cycles after request.
- Read address 0x23 (channel 2), slave 2 acks after 3 wait cycles with 0xCAFEF00D, slave 1 acks spuriously meanwhile -> spurious ack ignored; wb_dat_o=0xCAFEF00D, single-cycle wb_ack_o.
- Read address 0x50 (sel=5, unmapped) -> no slave strobe, wb_ack_o one cycle after sampling with wb_dat_o=0, err_unmapped=1.
- Read channel 1 with slave never acking, TIMEOUT=255 -> stb held 255 cycles then dropped; wb_ack_o=1, wb_dat_o=0, err_timeout=1; err_clr pulse -> both flags 0.
- Access channel 3, deassert wb_cyc_i in the 2nd BUSY cycle -> s_wb_stb_o=0 next cycle, wb_ack_o stays 0, back in IDLE; a following request completes normally.
- Assert rst during BUSY with err_timeout set -> next cycle all outputs 0; err_clr and a new unmapped error on the same edge -> err_unmapped=1.

Source files
------------

// File: rtl/wb_bus_dispatch.sv
// Wishbone classic interconnect: one master, NUM_CHAN slaves selected by the
// upper address bits. Registers the slave response back to the master and
// completes unmapped accesses and ack timeouts on the slave's behalf, raising
// sticky error flags for both.
module wb_bus_dispatch #(
    parameter int NUM_CHAN = 4,
    parameter int ADDR_W   = 7,
    parameter int SUB_AW   = 4,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_stb_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_we_i,
    input  logic [ADDR_W-1:0]          wb_adr_i,
    input  logic [DATA_W-1:0]          wb_dat_i,
    output logic [DATA_W-1:0]          wb_dat_o,
    output logic                       wb_ack_o,
    output logic [NUM_CHAN-1:0]        s_wb_stb_o,
    output logic [NUM_CHAN-1:0]        s_wb_cyc_o,
    output logic                       s_wb_we_o,
    output logic [SUB_AW-1:0]          s_wb_adr_o,
    output logic [DATA_W-1:0]          s_wb_dat_o,
    input  logic [NUM_CHAN*DATA_W-1:0] s_wb_dat_i,
    input  logic [NUM_CHAN-1:0]        s_wb_ack_i,
    input  logic                       err_clr,
    output logic                       err_unmapped,
    output logic                       err_timeout
);

    localparam int SEL_W = ADDR_W - SUB_AW;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CHAN-1:0] stb_q, stb_d;
    logic                s_we_q, s_we_d;
    logic [SUB_AW-1:0]   s_adr_q, s_adr_d;
    logic [DATA_W-1:0]   s_dat_q, s_dat_d;
    logic [DATA_W-1:0]   m_dat_q, m_dat_d;
    logic                m_ack_q, m_ack_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_unm_q, err_unm_d;
    logic                err_to_q, err_to_d;

    logic [SEL_W-1:0]    sel;
    logic                sel_ack;
    logic [DATA_W-1:0]   sel_rdata;
    logic                set_unm;
    logic                set_to;

    assign sel = wb_adr_i[ADDR_W-1:SUB_AW];

    // The held one-hot strobe doubles as the channel select in BUSY, so the
    // ack and read-data muxes are masked by it instead of indexing by sel.
    always_comb begin
        sel_ack   = |(s_wb_ack_i & stb_q);
        sel_rdata = '0;
        for (int unsigned n = 0; n < NUM_CHAN; n++) begin
            if (stb_q[n]) begin
                sel_rdata = sel_rdata | s_wb_dat_i[n*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: request decode, slave wait/timeout/abort, ack pulse.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        s_we_d  = s_we_q;
        s_adr_d = s_adr_q;
        s_dat_d = s_dat_q;
        m_dat_d = m_dat_q;
        m_ack_d = 1'b0;
        cnt_d   = cnt_q;
        set_unm = 1'b0;
        set_to  = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    s_adr_d = wb_adr_i[SUB_AW-1:0];
                    s_we_d  = wb_we_i;
                    s_dat_d = wb_dat_i;
                    if (32'(sel) < NUM_CHAN) begin
                        for (int unsigned n = 0; n < NUM_CHAN; n++) begin
                            stb_d[n] = (32'(sel) == n);
                        end
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        stb_d   = '0;
                        m_dat_d = '0;
                        m_ack_d = 1'b1;
                        set_unm = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            BUSY: begin
                if (!wb_cyc_i) begin
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    stb_d   = '0;
                    m_dat_d = s_we_q ? '0 : sel_rdata;
                    m_ack_d = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
                        stb_d   = '0;
                        m_dat_d = '0;
                        m_ack_d = 1'b1;
                        set_to  = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Setting an error wins over a clear on the same edge.
        err_unm_d = set_unm | (err_unm_q & ~err_clr);
        err_to_d  = set_to  | (err_to_q  & ~err_clr);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            stb_q     <= '0;
            s_we_q    <= 1'b0;
            s_adr_q   <= '0;
            s_dat_q   <= '0;
            m_dat_q   <= '0;
            m_ack_q   <= 1'b0;
            cnt_q     <= '0;
            err_unm_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stb_q     <= stb_d;
            s_we_q    <= s_we_d;
            s_adr_q   <= s_adr_d;
            s_dat_q   <= s_dat_d;
            m_dat_q   <= m_dat_d;
            m_ack_q   <= m_ack_d;
            cnt_q     <= cnt_d;
            err_unm_q <= err_unm_d;
            err_to_q  <= err_to_d;
        end
    end

    assign s_wb_stb_o   = stb_q;
    assign s_wb_cyc_o   = stb_q;
    assign s_wb_we_o    = s_we_q;
    assign s_wb_adr_o   = s_adr_q;
    assign s_wb_dat_o   = s_dat_q;
    assign wb_dat_o     = m_dat_q;
    assign wb_ack_o     = m_ack_q;
    assign err_unmapped = err_unm_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_wb_bus_dispatch.sv
// Scoreboard bench for wb_bus_dispatch: the stimulus pushes each expected
// master response, a negedge monitor pops and compares on every wb_ack_o.
module tb_wb_bus_dispatch;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_stb_i, wb_cyc_i, wb_we_i;
    logic [6:0]   wb_adr_i;
    logic [31:0]  wb_dat_i;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic [3:0]   s_wb_stb_o, s_wb_cyc_o;
    logic         s_wb_we_o;
    logic [3:0]   s_wb_adr_o;
    logic [31:0]  s_wb_dat_o;
    logic [127:0] s_wb_dat_i;
    logic [3:0]   s_wb_ack_i;
    logic         err_clr;
    logic         err_unmapped, err_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] dat;
        logic        eu;
        logic        et;
    } exp_t;
    exp_t exp_q[$];

    // Slave models: fixed read data, ack after wait_n strobe cycles if enabled.
    logic [3:0]  ack_en;
    logic [3:0]  spur;
    int unsigned wait_n [4];
    int unsigned scnt   [4];

    assign s_wb_dat_i = {32'h33333333, 32'hCAFEF00D, 32'hBADBAD01, 32'h11110000};

    always #5 clk = ~clk;

    wb_bus_dispatch #(
        .NUM_CHAN(4),
        .ADDR_W  (7),
        .SUB_AW  (4),
        .DATA_W  (32),
        .TIMEOUT (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .s_wb_stb_o  (s_wb_stb_o),
        .s_wb_cyc_o  (s_wb_cyc_o),
        .s_wb_we_o   (s_wb_we_o),
        .s_wb_adr_o  (s_wb_adr_o),
        .s_wb_dat_o  (s_wb_dat_o),
        .s_wb_dat_i  (s_wb_dat_i),
        .s_wb_ack_i  (s_wb_ack_i),
        .err_clr     (err_clr),
        .err_unmapped(err_unmapped),
        .err_timeout (err_timeout)
    );

    always @(posedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (s_wb_stb_o[ch]) scnt[ch] <= scnt[ch] + 1;
            else                scnt[ch] <= 0;
        end
    end

    always_comb begin
        s_wb_ack_i = '0;
        for (int ch = 0; ch < 4; ch++) begin
            s_wb_ack_i[ch] = spur[ch] | (s_wb_stb_o[ch] & ack_en[ch] & (scnt[ch] == wait_n[ch]));
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: every master ack must match the oldest expected response.
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (wb_ack_o) begin
            chk("ack_single_cycle", {63'd0, prev_ack}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", {63'd0, wb_ack_o}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_dat", {32'd0, wb_dat_o}, {32'd0, e.dat});
                chk("rsp_err_unmapped", {63'd0, err_unmapped}, {63'd0, e.eu});
                chk("rsp_err_timeout", {63'd0, err_timeout}, {63'd0, e.et});
            end
        end
        prev_ack <= wb_ack_o;
    end

    task automatic do_req(input logic [6:0] adr, input logic we, input logic [31:0] wdat,
                          input logic [3:0] exp_stb, input int exp_lat, input logic [31:0] exp_dat,
                          input logic eu, input logic et, input logic clr);
        int  n;
        logic got;
        exp_q.push_back('{exp_dat, eu, et});
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
        err_clr  = clr;
        n = 0; got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 2) err_clr = 1'b0;
            if (wb_ack_o) begin
                got = 1'b1;
            end else if (n >= 2) begin
                chk("s_stb_held", {60'd0, s_wb_stb_o}, {60'd0, exp_stb});
                chk("s_cyc_held", {60'd0, s_wb_cyc_o}, {60'd0, exp_stb});
                if (n == 2) begin
                    chk("s_adr", {60'd0, s_wb_adr_o}, {60'd0, adr[3:0]});
                    chk("s_we", {63'd0, s_wb_we_o}, {63'd0, we});
                    chk("s_dat", {32'd0, s_wb_dat_o}, {32'd0, wdat});
                end
            end
        end
        chk("ack_seen", {63'd0, got}, 64'd1);
        chk("latency", 64'(n), 64'(exp_lat));
        chk("s_stb_at_ack", {60'd0, s_wb_stb_o}, 64'd0);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
        chk("ack_dropped", {63'd0, wb_ack_o}, 64'd0);
        chk("dat_hold", {32'd0, wb_dat_o}, {32'd0, exp_dat});
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ack"}, {63'd0, wb_ack_o}, 64'd0);
        chk({nm, "_dat"}, {32'd0, wb_dat_o}, 64'd0);
        chk({nm, "_stb_cyc"}, {56'd0, s_wb_stb_o, s_wb_cyc_o}, 64'd0);
        chk({nm, "_we_adr_sdat"}, {27'd0, s_wb_we_o, s_wb_adr_o, s_wb_dat_o}, 64'd0);
        chk({nm, "_flags"}, {62'd0, err_unmapped, err_timeout}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; err_clr = 1'b0;
        ack_en = 4'b0101; spur = 4'b0000;
        wait_n[0] = 0; wait_n[1] = 0; wait_n[2] = 3; wait_n[3] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Read channel 2 (3 wait cycles) while channel 1 acks spuriously.
        spur = 4'b0010;
        do_req(7'h23, 1'b0, 32'h0, 4'b0100, 6, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
        spur = 4'b0000;

        // Write channel 0, immediate ack; writes return zero data.
        do_req(7'h05, 1'b1, 32'h12345678, 4'b0001, 3, 32'h0, 1'b0, 1'b0, 1'b0);

        // Unmapped channel 5.
        do_req(7'h50, 1'b0, 32'h0, 4'b0000, 2, 32'h0, 1'b1, 1'b0, 1'b0);

        // Channel 1 never acks: times out after 255 strobe cycles.
        do_req(7'h10, 1'b0, 32'h0, 4'b0010, 257, 32'h0, 1'b1, 1'b1, 1'b0);

        // Clear pulse drops both flags.
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("flags_cleared", {62'd0, err_unmapped, err_timeout}, 64'd0);

        // Abort a channel-3 access in its second BUSY cycle.
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 7'h35;
        @(negedge clk);
        @(negedge clk);
        chk("abort_stb_busy1", {60'd0, s_wb_stb_o}, 64'h8);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        chk("abort_stb_busy2", {60'd0, s_wb_stb_o}, 64'h8);
        @(negedge clk);
        chk("abort_stb_drop", {60'd0, s_wb_stb_o}, 64'd0);
        chk("abort_no_ack", {63'd0, wb_ack_o}, 64'd0);
        chk("abort_no_err", {62'd0, err_unmapped, err_timeout}, 64'd0);

        // Following request completes normally.
        do_req(7'h07, 1'b0, 32'h0, 4'b0001, 3, 32'h11110000, 1'b0, 1'b0, 1'b0);

        // Set err_timeout again, then reset during a BUSY access.
        do_req(7'h1A, 1'b0, 32'h0, 4'b0010, 257, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 7'h12; wb_dat_i = 32'hA5A5A5A5;
        repeat (3) @(negedge clk);
        chk("pre_rst_stb", {60'd0, s_wb_stb_o}, 64'h2);
        chk("pre_rst_err_timeout", {63'd0, err_timeout}, 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = '0; wb_adr_i = '0;
        @(negedge clk);
        chk_all_zero("mid_rst");

        // err_clr on the same edge as a new unmapped error: set wins.
        do_req(7'h60, 1'b0, 32'h0, 4'b0000, 2, 32'h0, 1'b1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
